data_mem_controller: RTL
========================

DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: the maximum number of cycles to wait for mem_ack before aborting the access.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rstN  input  1  reset, synchronous, active-low.
REQ-004 MemRead  input  1  load request from the EX/MEM stage.
REQ-005 MemWrite  input  1  store request from the EX/MEM stage.
REQ-006 funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 addr  input  32  byte address of the access.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 rdata  output  32  load result after alignment and sign/zero extension.
REQ-010 mem_ready  output  1  high = idle or access complete; low = access in progress (consumed by the pipeline stall logic).
REQ-011 misaligned  output  1  the completed access was misaligned or used an illegal funct3.
REQ-012 bus_err  output  1  the completed access timed out.
REQ-013 mem_req  output  1  external memory request, held high until mem_ack.
REQ-014 mem_we  output  1  external write enable.
REQ-015 mem_addr  output  30  word address (addr[31:2]).
REQ-016 mem_be  output  4  byte-lane enables.
REQ-017 mem_wdata  output  32  lane-steered store data.
REQ-018 mem_rdata  input  32  external read data, valid with mem_ack.
REQ-019 mem_ack  input  1  single-cycle completion from external memory.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS, FAULT and DONE.
REQ-021 IDLE: mem_ready=1 and mem_req=0; when MemRead or MemWrite is high, the block SHALL latch addr, funct3, wdata and the direction, then move to ACCESS (aligned) or FAULT (misaligned/illegal).
REQ-022 When MemRead and MemWrite are both high, the access SHALL be a read and MemWrite SHALL be ignored.
REQ-023 Misaligned: h/hu/sb-sized rules -- h/hu or half store with addr[0]=1; w with addr[1:0]!=0; any funct3 not listed for that direction (stores: 000/001/010 only).
REQ-024 ACCESS: mem_req=1 and mem_ready=0; on mem_ack the block SHALL capture rdata (reads) and go to DONE; mem_req SHALL drop the cycle after mem_ack.
REQ-025 ACCESS timeout counter: the counter SHALL be 8 bits wide, cleared on entry and incremented each ACCESS cycle; on reaching TIMEOUT_CYCLES without mem_ack the block SHALL drop mem_req, set bus_err and rdata=0, and go to DONE.
REQ-026 mem_ack and timeout in the same cycle: mem_ack SHALL win and bus_err SHALL stay 0.
REQ-027 FAULT: one cycle with mem_ready=0 and mem_req=0, then DONE with misaligned=1 and rdata=0.
REQ-028 DONE: one cycle with mem_ready=1; rdata, misaligned and bus_err valid; then IDLE. The minimum access latency is 3 cycles (IDLE, ACCESS, DONE).
REQ-029 rdata, misaligned and bus_err SHALL hold until the next access begins.
REQ-030 Loads: the byte/half SHALL be selected by addr[1:0]; b/h sign-extended, bu/hu zero-extended, w passed through.
REQ-031 Stores: mem_be SHALL be 0001<<addr[1:0] for sb, 0011<<addr[1:0] for sh, and 1111 for sw; mem_wdata SHALL be the byte replicated x4 for sb, the half replicated x2 for sh, and the full word for sw.
REQ-032 mem_addr, mem_we, mem_be and mem_wdata SHALL be driven from latched values, stable throughout ACCESS.
REQ-033 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-034 When rstN=0 at a clock edge: state IDLE, counter 0, rdata 0, misaligned 0, bus_err 0, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0; mem_ready=1.
REQ-035 Reset during ACCESS SHALL drop mem_req on the following cycle, and any later mem_ack SHALL be ignored.

Structure
REQ-036 A shared package SHALL hold the state enum and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-037 The combinational lane steering/extension SHALL be a sub-module load_store_align; the FSM, counter and latches SHALL be in data_mem_controller.

Verification
REQ-038 lw addr=0x100, mem_ack after 2 ACCESS cycles, mem_rdata=0xDEADBEEF -> mem_ready low for 3 cycles, rdata=0xDEADBEEF in DONE.
REQ-039 lb addr=0x103, mem_rdata=0x80FFFFFF -> rdata=0xFFFFFF80; the same access with lbu -> rdata=0x00000080.
REQ-040 sh addr=0x102, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-041 lw addr=0x101 -> no mem_req, FAULT one cycle, DONE misaligned=1, rdata=0.
REQ-042 sw with no mem_ack, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then DONE with bus_err=1.
REQ-043 MemRead=MemWrite=1, then rstN=0 mid-ACCESS -> mem_we=0 during access; after reset mem_req=0, mem_ready=1, and a late mem_ack has no effect.

Source files
------------

// File: rtl/data_mem_controller_pkg.sv
// Shared types and constants for the data memory controller: FSM states,
// funct3 access codes and the alignment/legality check.
package data_mem_controller_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_FAULT  = 2'b10,
      S_DONE   = 2'b11
   } state_t;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Stores only accept the signed-size codes; unsigned codes are load-only.
   function automatic logic access_illegal(input logic       is_write,
                                           input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
      logic bad;
      case (f3)
         LB:      bad = 1'b0;
         LH:      bad = addr_lo[0];
         LW:      bad = (addr_lo != 2'b00);
         LBU:     bad = is_write;
         LHU:     bad = is_write | addr_lo[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_mem_controller_load_store_align.sv
// Combinational byte-lane steering for stores and lane select plus
// sign/zero extension for loads.
module load_store_align
   import data_mem_controller_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata_word,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = 8'(i_rdata_word >> {i_addr_lo, 3'b000});
   assign w_half = 16'(i_rdata_word >> {i_addr_lo[1], 4'b0000});

   // Size is funct3[1:0] for both loads and stores.
   always_comb begin
      o_be    = 4'b0000;
      o_wdata = 32'h0000_0000;
      case (i_funct3[1:0])
         2'b00: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            o_be    = 4'b0011 << i_addr_lo;
            o_wdata = {2{i_wdata[15:0]}};
         end
         2'b10: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
         end
         default: begin
            o_be    = 4'b0000;
            o_wdata = 32'h0000_0000;
         end
      endcase
   end

   always_comb begin
      o_rdata = 32'h0000_0000;
      case (i_funct3)
         LB:      o_rdata = {{24{w_byte[7]}}, w_byte};
         LH:      o_rdata = {{16{w_half[15]}}, w_half};
         LW:      o_rdata = i_rdata_word;
         LBU:     o_rdata = {24'h00_0000, w_byte};
         LHU:     o_rdata = {16'h0000, w_half};
         default: o_rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/data_mem_controller.sv
// Load/store unit front end: latches one pipeline memory request, runs it on
// the external bus with an ack timeout, and reports aligned/extended results.
module data_mem_controller
   import data_mem_controller_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        rstN,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        mem_ready,
   output logic        misaligned,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_funct3;
   logic        r_we;
   logic        r_mem_req;
   logic        r_mem_ready;
   logic [31:0] r_rdata;
   logic        r_misaligned;
   logic        r_bus_err;

   logic        w_start;
   logic        w_start_we;
   logic        w_bad;
   logic        w_timeout;
   logic [3:0]  w_be;
   logic [31:0] w_wdata_st;
   logic [31:0] w_rdata_ext;

   // A simultaneous read and write request is treated as a read.
   assign w_start    = MemRead | MemWrite;
   assign w_start_we = MemWrite & ~MemRead;
   assign w_bad      = access_illegal(w_start_we, funct3, addr[1:0]);
   assign w_timeout  = (r_cnt == LP_CNT_LAST);

   load_store_align u_align (
      .i_funct3     (r_funct3),
      .i_addr_lo    (r_addr[1:0]),
      .i_wdata      (r_wdata),
      .i_rdata_word (mem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata_st),
      .o_rdata      (w_rdata_ext)
   );

   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Ack has priority over the timeout in the same cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_next = w_bad ? S_FAULT : S_ACCESS;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_ACCESS: begin
            if (mem_ack || w_timeout) begin
               w_next = S_DONE;
            end else begin
               w_next = S_ACCESS;
            end
         end
         S_FAULT: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_cnt        <= 8'd0;
         r_addr       <= 32'h0000_0000;
         r_wdata      <= 32'h0000_0000;
         r_funct3     <= 3'b000;
         r_we         <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_ready  <= 1'b1;
         r_rdata      <= 32'h0000_0000;
         r_misaligned <= 1'b0;
         r_bus_err    <= 1'b0;
      end else begin
         r_mem_req   <= (w_next == S_ACCESS);
         r_mem_ready <= (w_next == S_IDLE) || (w_next == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_addr       <= addr;
                  r_wdata      <= wdata;
                  r_funct3     <= funct3;
                  r_we         <= w_start_we;
                  r_cnt        <= 8'd0;
                  r_rdata      <= 32'h0000_0000;
                  r_misaligned <= 1'b0;
                  r_bus_err    <= 1'b0;
               end
            end
            S_ACCESS: begin
               r_cnt <= r_cnt + 8'd1;
               if (mem_ack) begin
                  if (!r_we) begin
                     r_rdata <= w_rdata_ext;
                  end
               end else if (w_timeout) begin
                  r_bus_err <= 1'b1;
                  r_rdata   <= 32'h0000_0000;
               end
            end
            S_FAULT: begin
               r_misaligned <= 1'b1;
               r_rdata      <= 32'h0000_0000;
            end
            default: ;
         endcase
      end
   end

   assign rdata      = r_rdata;
   assign mem_ready  = r_mem_ready;
   assign misaligned = r_misaligned;
   assign bus_err    = r_bus_err;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_we & r_mem_req;
   assign mem_addr   = r_addr[31:2];
   assign mem_be     = r_mem_req ? w_be : 4'b0000;
   assign mem_wdata  = (r_mem_req && r_we) ? w_wdata_st : 32'h0000_0000;

endmodule
